// File: rtl/bin2dec_seq.sv
// Sequential binary-to-BCD converter for the DC value display: scales an ADC code,
// then runs shift-add-3 one bit per clock with saturation and a display hold.
module bin2dec_seq #(
  parameter int BIN_W       = 12,
  parameter int NUM_DIGITS  = 6,
  parameter int SCALE_MUL   = 100,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bindata,
  input  logic                    hold,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] digits
);

  localparam int VAL_W = BIN_W + 16 - SCALE_SHIFT;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int PRD_W = BIN_W + 16;
  localparam logic [15:0] MUL16 = 16'(SCALE_MUL);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [BIN_W-1:0]  data_q;
  logic [VAL_W-1:0]  sr, sr_nxt, val;
  logic [BCD_W-1:0]  bcd, bcd_adj, bcd_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_q;
  logic [PRD_W-1:0]  product;
  logic              accept, last_shift;

  assign accept     = (state == IDLE) && start && !hold;
  assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

  assign product = {16'd0, data_q} * {{BIN_W{1'b0}}, MUL16};
  assign val     = VAL_W'(product >> SCALE_SHIFT);

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // see pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults are assigned before the case so no path leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    begin busy = 1'b1; state_nxt = SHIFT; end
      SHIFT:   begin busy = 1'b1; if (last_shift) state_nxt = DONE; end
      DONE:    begin done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Digits >= 5 get +3 before the shift so each nibble carries cleanly at 10.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_nxt = {bcd_adj[BCD_W-2:0], sr[VAL_W-1]};
  assign sr_nxt  = {sr[VAL_W-2:0], 1'b0};

  // NOTE: the conversion datapath carries no reset; every register here is
  // loaded in IDLE/LOAD before it is read, so a reset would only cost logic.
  always_ff @(posedge clk) begin
    if (accept) data_q <= bindata;
    if (state == LOAD) begin
      sr    <= val;
      bcd   <= '0;
      cnt   <= CNT_W'(VAL_W);
      ovf_q <= (64'(val) >= LIMIT);
    end else if (state == SHIFT) begin
      sr  <= sr_nxt;
      bcd <= bcd_nxt;
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Results publish on the edge entering DONE so they are visible while done=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits   <= '0;
      overflow <= 1'b0;
    end else if (last_shift && !hold) begin
      digits   <= ovf_q ? {NUM_DIGITS{4'h9}} : bcd_nxt;
      overflow <= ovf_q;
    end
  end

endmodule

// File: tb/tb_bin2dec_seq.sv
// Scoreboard bench for bin2dec_seq: three parameterisations share one stimulus stream;
// expected results come from decimal arithmetic and are checked when done pulses.
module tb_bin2dec_seq;

  logic        clk = 1'b0;
  logic        rst, start, hold;
  logic [11:0] bindata;

  logic        busy0, done0, ovf0;
  logic [23:0] d0;
  logic        busy1, done1, ovf1;
  logic [15:0] d1;
  logic        busy2, done2, ovf2;
  logic [23:0] d2;

  bin2dec_seq u_dflt (
    .clk(clk), .rst(rst), .start(start), .bindata(bindata), .hold(hold),
    .busy(busy0), .done(done0), .overflow(ovf0), .digits(d0));

  bin2dec_seq #(.NUM_DIGITS(4)) u_four (
    .clk(clk), .rst(rst), .start(start), .bindata(bindata), .hold(hold),
    .busy(busy1), .done(done1), .overflow(ovf1), .digits(d1));

  bin2dec_seq #(.SCALE_MUL(1000), .SCALE_SHIFT(12)) u_scl (
    .clk(clk), .rst(rst), .start(start), .bindata(bindata), .hold(hold),
    .busy(busy2), .done(done2), .overflow(ovf2), .digits(d2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] dig;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        q0[$], q1[$], q2[$];
  exp_t        e0, e1, e2;
  logic [23:0] pub_dig [3];
  logic        pub_ovf [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Decimal reference: scale with integer arithmetic, saturate at 10^nd.
  function automatic exp_t model(input int b, input int mul, input int sh, input int nd);
    exp_t   e;
    longint v, lim;
    v   = (longint'(b) * longint'(mul)) >> sh;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    e.dig = '0;
    e.ovf = (v >= lim);
    for (int i = 0; i < nd; i++) begin
      e.dig[4*i +: 4] = e.ovf ? 4'd9 : 4'(v % 10);
      v = v / 10;
    end
    e.cyc = 0;
    return e;
  endfunction

  task automatic push_all(input int b, input bit keep);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       e = model(b, 100, 0, 6);
        1:       e = model(b, 100, 0, 4);
        default: e = model(b, 1000, 12, 6);
      endcase
      if (keep) begin
        e.dig = pub_dig[k];
        e.ovf = pub_ovf[k];
      end else begin
        pub_dig[k] = e.dig;
        pub_ovf[k] = e.ovf;
      end
      e.cyc = cyc;
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  // Returns #1 after the accept edge (first busy cycle).
  task automatic issue(input int b, input bit keep);
    @(posedge clk); #1;
    bindata = 12'(b);
    start   = 1'b1;
    push_all(b, keep);
    @(posedge clk); #1;
    start   = 1'b0;
    bindata = 12'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_in_time", 64'(n < 100), 64'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (done0) begin
      check("u_dflt_done_expected", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check("u_dflt_digits", 64'(d0), 64'(e0.dig));
        check("u_dflt_overflow", 64'(ovf0), 64'(e0.ovf));
        check("u_dflt_latency", 64'(cyc - e0.cyc), 64'd30);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done1) begin
      check("u_four_done_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("u_four_digits", 64'(d1), 64'(e1.dig[15:0]));
        check("u_four_overflow", 64'(ovf1), 64'(e1.ovf));
        check("u_four_latency", 64'(cyc - e1.cyc), 64'd30);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done2) begin
      check("u_scl_done_expected", 64'(q2.size() != 0), 64'd1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        check("u_scl_digits", 64'(d2), 64'(e2.dig));
        check("u_scl_overflow", 64'(ovf2), 64'(e2.ovf));
        check("u_scl_latency", 64'(cyc - e2.cyc), 64'd18);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; bindata = '0;
    for (int k = 0; k < 3; k++) begin pub_dig[k] = '0; pub_ovf[k] = 1'b0; end
    cycles(3);
    check("reset_busy", 64'({busy0, busy1, busy2}), 64'd0);
    check("reset_done", 64'({done0, done1, done2}), 64'd0);
    check("reset_overflow", 64'({ovf0, ovf1, ovf2}), 64'd0);
    check("reset_digits", {d0, d1, d2}, 64'd0);
    rst = 1'b0;

    // Full-scale sample with explicit busy/done timing on the default instance.
    issue(4095, 1'b0);
    check("t1_busy_cycle1", 64'(busy0), 64'd1);
    cycles(28);
    check("t1_busy_cycle29", 64'(busy0), 64'd1);
    check("t1_no_done_cycle29", 64'(done0), 64'd0);
    cycles(1);
    check("t1_done_cycle30", 64'(done0), 64'd1);
    check("t1_busy_low_cycle30", 64'(busy0), 64'd0);
    check("t1_digits", 64'(d0), 64'h409500);
    wait_idle();

    foreach (e0.dig[i]) ; // no-op keeps e0 referenced only by the monitor
    issue(0, 1'b0);    wait_idle();
    issue(1, 1'b0);    wait_idle();
    check("t2_digits_1", 64'(d0), 64'h000100);
    issue(2048, 1'b0); wait_idle();
    issue(100, 1'b0);  wait_idle();
    check("t3_sat_digits", 64'(d1), 64'h9999);
    check("t3_sat_flag", 64'(ovf1), 64'd1);
    issue(99, 1'b0);   wait_idle();
    issue(4095, 1'b0); wait_idle();
    check("t4_truncated", 64'(d2), 64'h000999);

    // Hold blocks new starts entirely.
    hold = 1'b1;
    @(posedge clk); #1;
    bindata = 12'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t5_hold_no_busy", 64'({busy0, busy1, busy2}), 64'd0);
    cycles(35);
    check("t5_hold_digits", 64'(d0), 64'h409500);
    hold = 1'b0;

    // Hold raised mid-conversion: done pulses but the result is discarded.
    issue(1, 1'b1);
    cycles(4);
    hold = 1'b1;
    wait_idle();
    hold = 1'b0;
    check("t5_discard_digits", 64'(d0), 64'h409500);

    // Re-pulsed start while busy must not queue a second conversion.
    issue(2048, 1'b0);
    cycles(3);
    bindata = 12'd5; start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_idle();
    cycles(40);

    // Reset during SHIFT aborts with no done.
    issue(3000, 1'b0);
    cycles(10);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("t6_rst_busy", 64'({busy0, busy1, busy2}), 64'd0);
    check("t6_rst_digits", {d0, d1, d2}, 64'd0);
    check("t6_rst_overflow", 64'({ovf0, ovf1, ovf2}), 64'd0);
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) begin pub_dig[k] = '0; pub_ovf[k] = 1'b0; end
    cycles(40);

    for (int n = 0; n < 15; n++) begin
      issue(int'($urandom_range(0, 4095)), 1'b0);
      wait_idle();
    end

    cycles(5);
    check("scoreboard_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
